// File: rtl/stream_sink_checker.sv
// Stream consumer that checks each accepted beat against an incrementing reference
// sequence. Define SINK_BACKPRESSURE_EN to throttle up_ready with an 8-bit LFSR.
module stream_sink_checker #(
  parameter int D_WIDTH   = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic                 start,
  input  logic [D_WIDTH-1:0]   seed,
  input  logic [CNT_WIDTH-1:0] beats,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] rx_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 first_err_valid,
  output logic [D_WIDTH-1:0]   first_err_data,
  output logic [1:0]           fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [D_WIDTH-1:0]   D_ONE   = {{(D_WIDTH-1){1'b0}}, 1'b1};

  // Handshake rule: a beat transfers on a rising edge where up_valid and up_ready
  // are both high; up_ready is a decode of registers only, never of up_valid.
  logic [1:0]           state;
  logic [D_WIDTH-1:0]   expected;
  logic [CNT_WIDTH-1:0] beats_q;
  logic                 hs;
  logic                 accept_start;

  assign hs           = up_valid & up_ready;
  assign accept_start = (state == S_IDLE) && start && (beats != '0);
  assign busy         = (state == S_RUN);
  assign done         = (state == S_DONE);
  assign fsm_state    = state;

`ifdef SINK_BACKPRESSURE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= 8'hA5;
    end else if (accept_start) begin
      lfsr <= 8'hA5;
    end else if (state == S_RUN) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign up_ready = (state == S_RUN) && (lfsr[1:0] != 2'b00);
`else
  assign up_ready = (state == S_RUN);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      expected        <= '0;
      beats_q         <= '0;
      rx_count        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_start) begin
            state           <= S_RUN;
            beats_q         <= beats;
            expected        <= seed;
            rx_count        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_data  <= '0;
          end
        end
        S_RUN: begin
          if (hs) begin
            rx_count <= rx_count + CNT_ONE;
            expected <= expected + D_ONE;
            // Compare against the value expected for this beat, before it advances.
            if (up_data != expected) begin
              if (err_count != '1) err_count <= err_count + CNT_ONE;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_data  <= up_data;
              end
            end
            if ((rx_count + CNT_ONE) == beats_q) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Randomized bench for stream_sink_checker: a source driver feeds runs, a reference
// model predicts the end-of-run results, and a monitor compares them at each done.
module tb_stream_sink_checker;

  localparam int DW = 6;
  localparam int CW = 16;
  localparam int W  = CW + CW + 1 + DW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] up_data;
  logic          up_valid;
  logic          up_ready;
  logic          start;
  logic [DW-1:0] seed;
  logic [CW-1:0] beats;
  logic          busy;
  logic          done;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] err_count;
  logic          first_err_valid;
  logic [DW-1:0] first_err_data;
  logic [1:0]    fsm_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] stim_q[$];

  stream_sink_checker #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .start(start), .seed(seed), .beats(beats), .busy(busy), .done(done),
    .rx_count(rx_count), .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_data(first_err_data), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Results the specification predicts for one run, from the beat list alone.
  task automatic model_run(input logic [DW-1:0] sd, input logic [CW-1:0] nb);
    logic [CW-1:0] e_err;
    logic          e_fev;
    logic [DW-1:0] e_fed;
    logic [DW-1:0] want;
    e_err = '0;
    e_fev = 1'b0;
    e_fed = '0;
    for (int k = 0; k < int'(nb); k++) begin
      want = DW'((int'(sd) + k) % (1 << DW));
      if (stim_q[k] != want) begin
        e_err++;
        if (!e_fev) begin
          e_fev = 1'b1;
          e_fed = stim_q[k];
        end
      end
    end
    exp_q.push_back({nb, e_err, e_fev, e_fed});
  endtask

  task automatic fill(input logic [DW-1:0] sd, input int n, input int bad_pct);
    logic [DW-1:0] v;
    stim_q.delete();
    for (int k = 0; k < n; k++) begin
      v = DW'((int'(sd) + k) % (1 << DW));
      if (int'($urandom_range(0, 99)) < bad_pct) v = v ^ DW'($urandom_range(1, 63));
      stim_q.push_back(v);
    end
  endtask

  // Source driver: called at posedge+1, returns at posedge+1.
  task automatic run(input logic [DW-1:0] sd, input logic [CW-1:0] nb, input int gap_pct,
                     input int restart_at, input int abort_at);
    int  i;
    int  cyc;
    bit  hs;
    bit  restarted;
    i = 0;
    cyc = 0;
    restarted = 0;
    if (abort_at < 0) model_run(sd, nb);
    start = 1'b1;
    seed  = sd;
    beats = nb;
    @(posedge clk); #1;
    start = 1'b0;
    while (i < int'(nb) && cyc < 4000) begin
      start = 1'b0;
      if (restart_at >= 0 && i == restart_at && !restarted) begin
        start = 1'b1;
        seed  = ~sd;
        beats = 16'd3;
        restarted = 1;
      end
      if (abort_at >= 0 && i == abort_at) begin
        up_valid = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort state", 32'(fsm_state), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(up_ready), 32'd0);
        check("abort rx_count", 32'(rx_count), 32'd0);
        check("abort err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        up_valid = 1'b0;
        return;
      end
      up_valid = (int'($urandom_range(0, 99)) >= gap_pct);
      up_data  = up_valid ? stim_q[i] : DW'($urandom);
      @(negedge clk);
      if (cyc == 0) check("busy after start", 32'(busy), 32'd1);
      hs = up_valid && up_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    start = 1'b0;
    up_valid = 1'b0;
    if (i < int'(nb)) begin
      check("run timeout beats", 32'(i), 32'(nb));
      return;
    end
    @(negedge clk);
    check("done after last beat", 32'(done), 32'd1);
    check("busy in done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done pulse width", 32'(done), 32'd0);
    check("idle after done", 32'(fsm_state), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare end-of-run results against the scoreboard.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rx_count", 32'(rx_count), 32'(e[W-1 -: CW]));
        check("err_count", 32'(err_count), 32'(e[DW+1+CW-1 -: CW]));
        check("first_err_valid", 32'(first_err_valid), 32'(e[DW]));
        check("first_err_data", 32'(first_err_data), 32'(e[DW-1:0]));
      end
    end
  end

  // Ready pattern monitor, from the specification's LFSR definition.
  always @(negedge clk) begin
    logic [7:0] m;
    logic       was_busy;
    logic       want;
    if (busy && !was_busy) m = 8'hA5;
`ifdef SINK_BACKPRESSURE_EN
    want = busy && (m[1:0] != 2'b00);
`else
    want = busy;
`endif
    check("up_ready pattern", 32'(up_ready), 32'(want));
    if (busy) m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    was_busy = busy;
  end

  initial begin
    rst = 1'b0;
    up_valid = 1'b1;
    up_data = '0;
    start = 1'b0;
    seed = '0;
    beats = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset ready", 32'(up_ready), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset rx_count", 32'(rx_count), 32'd0);
      check("reset err_count", 32'(err_count), 32'd0);
      check("reset first_err_valid", 32'(first_err_valid), 32'd0);
      check("reset first_err_data", 32'(first_err_data), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle ready no start", 32'(up_ready), 32'd0);
    end
    up_valid = 1'b0;
    @(posedge clk); #1;

    stim_q = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
    run(6'd0, 16'd10, 0, -1, -1);
    stim_q = '{6'd62, 6'd63, 6'd0, 6'd1};
    run(6'd62, 16'd4, 20, -1, -1);
    stim_q = '{6'd5, 6'd6, 6'd9, 6'd8, 6'd3, 6'd10};
    run(6'd5, 16'd6, 0, -1, -1);

    start = 1'b1;
    seed = 6'd7;
    beats = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("zero beats stays idle", 32'(fsm_state), 32'd0);
      check("zero beats rx_count held", 32'(rx_count), 32'd6);
      check("zero beats err_count held", 32'(err_count), 32'd2);
      check("zero beats first_err_data held", 32'(first_err_data), 32'd9);
    end
    @(posedge clk); #1;

    stim_q = '{6'd4};
    run(6'd4, 16'd1, 0, -1, -1);

    fill(6'd17, 20, 10);
    run(6'd17, 16'd20, 25, 7, -1);

    for (int r = 0; r < 6; r++) begin
      logic [DW-1:0] s;
      int n;
      s = DW'($urandom);
      n = int'($urandom_range(1, 40));
      fill(s, n, 15);
      run(s, CW'(n), int'($urandom_range(0, 40)), -1, -1);
    end

    fill(6'd33, 100, 0);
    run(6'd33, 16'd100, 0, -1, -1);

    fill(6'd50, 100, 0);
    run(6'd50, 16'd100, 0, -1, 50);
    repeat (2) @(posedge clk);
    #1;

    fill(6'd1, 12, 30);
    run(6'd1, 16'd12, 10, -1, -1);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_sink_checker.md
# stream_sink_checker

Valid/ready stream consumer for the downstream end of the pipeline chain. It is the responder: it drives `up_ready`, accepts beats, and checks each beat against an incrementing reference sequence. It counts received beats and mismatches, and captures the first bad beat. It sits at the `down_*` port of a shift-register/FIFO pipeline in block-level and FPGA test builds, and can apply pseudo-random backpressure.

## Interface
- `D_WIDTH`, 6, data width; the expected sequence wraps modulo 2^D_WIDTH.
- `CNT_WIDTH`, 16, width of the beat and error counters.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `up_data`  in  D_WIDTH  stream data from the pipeline output.
- `up_valid`  in  1  stream valid.
- `up_ready`  out  1  stream ready; derived only from registers, with no combinational path from `up_valid`/`up_data`.
- `start`  in  1  one-cycle pulse that begins a run.
- `seed`  in  D_WIDTH  first expected value, sampled on `start`.
- `beats`  in  CNT_WIDTH  number of beats in the run, sampled on `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the run completes.
- `rx_count`  out  CNT_WIDTH  beats accepted in the current or last run.
- `err_count`  out  CNT_WIDTH  mismatching beats; saturates at all-ones.
- `first_err_valid`  out  1  a mismatch has been captured this run.
- `first_err_data`  out  D_WIDTH  `up_data` of the first mismatching beat.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE → RUN** on `start`=1 with `beats`≠0.
  - Latch `beats` and set expected ← `seed`.
  - Clear `rx_count`, `err_count`, `first_err_valid`, `first_err_data`.
  - Reload the LFSR to 8'hA5.
- `start` with `beats`=0 is ignored; the FSM stays in IDLE and all outputs are unchanged.
- **RUN:** a handshake is `up_valid & up_ready`. On each handshake:
  - `rx_count` += 1.
  - expected += 1, modulo 2^D_WIDTH (wraps, e.g. 63 → 0 for D_WIDTH=6).
  - If `up_data` ≠ expected, `err_count` += 1 (saturating).
  - On the first mismatch, `first_err_valid` ← 1 and `first_err_data` ← `up_data`; later mismatches do not overwrite them.
- **RUN → DONE** on the handshake that makes `rx_count` equal the latched `beats`.
- **DONE → IDLE** unconditionally after one cycle; `done`=1 only in DONE.
- `start` in RUN or DONE is ignored.
- Counters and capture registers hold their values in IDLE until the next accepted `start`.
- `up_ready`=0 in IDLE and DONE, so no beat is consumed outside a run.
- `up_valid` with `up_ready`=0 is not a handshake; data is not sampled.
- Reset mid-run returns to IDLE immediately and discards the run; in-flight data stays in the upstream pipeline.

## Timing
- All outputs are registered state or decodes of state.
- Reset values: `up_ready`=0, `busy`=0, `done`=0, `rx_count`=0, `err_count`=0, `first_err_valid`=0, `first_err_data`=0; FSM in IDLE; LFSR = 8'hA5.
- `start` sampled at edge N gives `busy`=1 from cycle N+1. `up_ready` can first be 1 in cycle N+1.
- Counter and capture updates are visible the cycle after the handshake.
- Final handshake in cycle M gives `done`=1 and `busy`=0 in cycle M+1, and IDLE in M+2.
- Minimum run length: `beats`=1 with `up_valid` held high completes in 3 cycles from `start` to IDLE.
- Full throughput: with backpressure disabled, one beat per cycle.

## Configuration
- Macro: `SINK_BACKPRESSURE_EN`.
- **Defined:**
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle in RUN and holds in IDLE/DONE.
  - `up_ready` = RUN & (`lfsr[1:0]` ≠ 2'b00), giving a deterministic ~75% ready duty.
- **Undefined:** no LFSR is built; `up_ready` = RUN.
- Check behaviour, counters and FSM are identical in both builds; only the ready pattern differs.

## Test plan
- **Reset/idle:** hold `rst`=0 for 3 cycles with `up_valid`=1 → all outputs at reset values; `up_ready` stays 0 after reset release with no `start`.
- **Clean run:** `seed`=0, `beats`=10, source drives 0..9 → `rx_count`=10, `err_count`=0, `first_err_valid`=0; `done` pulses once, exactly 1 cycle after the 10th handshake.
- **Wrap:** D_WIDTH=6, `seed`=62, `beats`=4, source drives 62,63,0,1 → `err_count`=0.
- **Errors:** `seed`=5, `beats`=6, source drives 5,6,9,8,3,10 → `err_count`=2, `first_err_data`=9.
- **Ignored starts:** `beats`=0 `start` → stays IDLE. `start` pulse mid-run → no restart; `rx_count` keeps counting.
- **Backpressure and reset mid-run:**
  - With `SINK_BACKPRESSURE_EN`, `beats`=100, valid always high → `up_ready` low on cycles where `lfsr[1:0]`=0; zero errors; `rx_count`=100.
  - Asserting `rst`=0 at beat 50 → IDLE, counters 0 next cycle.
